serial_addsub_param: RTL and testbench

//   Parametrised multi-bit-per-cycle serial adder/subtractor. Successor to the 8-bit, 1-bit/cycle serial adder.

---
 rtl/serial_addsub_param.sv | 141 ++++++++++++++
 tb/tb_serial_addsub_param.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_param.sv
// Serial adder/subtractor: DIGIT bits per cycle, valid/ready on operand and result sides.
// Subtract is A + ~B + 1; cout is the carry out of the MSB and ovf is the signed overflow.
module serial_addsub_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  // One digit of the ripple: low DIGIT bits of both operands plus the running carry.
  logic [DIGIT-1:0] dig_a_c;
  logic [DIGIT-1:0] dig_b_c;
  logic [DIGIT:0]   dig_sum_c;
  logic             msb_cin_c;

  assign dig_a_c   = a_q[DIGIT-1:0];
  assign dig_b_c   = b_q[DIGIT-1:0];
  assign dig_sum_c = (DIGIT+1)'(dig_a_c) + (DIGIT+1)'(dig_b_c) + (DIGIT+1)'(carry_q);
  // Carry into the top bit of the digit recovered from that bit's sum and operands.
  assign msb_cin_c = dig_a_c[DIGIT-1] ^ dig_b_c[DIGIT-1] ^ dig_sum_c[DIGIT-1];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          res_d   = '0;
          cnt_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = (res_q >> DIGIT) | (WIDTH'(dig_sum_c[DIGIT-1:0]) << (WIDTH - DIGIT));
        carry_d = dig_sum_c[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          cout_d  = dig_sum_c[DIGIT];
          ovf_d   = msb_cin_c ^ dig_sum_c[DIGIT];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = res_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub_param.sv
// Bench for serial_addsub_param: an 8-bit/1-bit-digit instance tracked cycle by cycle against
// an arithmetic model, plus 16-bit instances with 4-bit and 16-bit digits for latency/wrap cases.
module tb_serial_addsub_param;

  logic clk;
  logic rst_n;

  logic       in_valid, out_ready, sub;
  logic [7:0] a8, b8;
  logic       in_ready, out_valid, cout, ovf, busy;
  logic [7:0] result;

  logic        iv16, or16, sub16;
  logic [15:0] a16, b16;
  logic        w4_ir, w4_ov, w4_c, w4_v, w4_bz;
  logic [15:0] w4_r;
  logic        w16_ir, w16_ov, w16_c, w16_v, w16_bz;
  logic [15:0] w16_r;

  int checks = 0;
  int errors = 0;

  serial_addsub_param #(.WIDTH(8), .DIGIT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a8), .b(b8), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .busy(busy)
  );

  serial_addsub_param #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(w4_ir),
    .a(a16), .b(b16), .sub(sub16), .out_valid(w4_ov), .out_ready(or16),
    .result(w4_r), .cout(w4_c), .ovf(w4_v), .busy(w4_bz)
  );

  serial_addsub_param #(.WIDTH(16), .DIGIT(16)) u_w16d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(w16_ir),
    .a(a16), .b(b16), .sub(sub16), .out_valid(w16_ov), .out_ready(or16),
    .result(w16_r), .cout(w16_c), .ovf(w16_v), .busy(w16_bz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: returns {ovf, cout, result} for a w-bit add or subtract.
  function automatic logic [33:0] ref_op(input int unsigned w, input logic [31:0] x,
                                         input logic [31:0] y, input logic s);
    longint unsigned m, xa, yb, sum;
    logic c, v, sx, sy, sr;
    m  = (64'd1 << w) - 64'd1;
    xa = longint'(x) & m;
    yb = longint'(y) & m;
    if (s) begin
      sum = (xa - yb) & m;
      c   = (xa >= yb);
    end else begin
      sum = xa + yb;
      c   = (sum > m);
      sum = sum & m;
    end
    sx = x[w-1];
    sy = y[w-1];
    sr = sum[w-1];
    v  = s ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
    return {v, c, 32'(sum)};
  endfunction

  // Cycle model of the 8-bit instance: cycles left in the computation, and whether a result is held.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [33:0] m_exp  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst in_ready", 34'(in_ready), 34'd1);
      chk("rst out_valid", 34'(out_valid), 34'd0);
      chk("rst busy", 34'(busy), 34'd0);
      chk("rst outputs", {ovf, cout, 24'd0, result}, 34'd0);
      m_left = 0;
      m_done = 1'b0;
    end else begin
      chk("cyc in_ready", 34'(in_ready), 34'(m_left == 0 && !m_done));
      chk("cyc out_valid", 34'(out_valid), 34'(m_done));
      chk("cyc busy", 34'(busy), 34'(m_left > 0));
      if (m_done)
        chk("cyc result", {ovf, cout, 24'd0, result}, m_exp);
      if (m_done) begin
        if (out_ready) m_done = 1'b0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (in_valid) begin
        m_left = 8;
        m_exp  = ref_op(8, 32'(a8), 32'(b8), sub);
      end
    end
  end

  // One 8-bit transaction; optionally holds the result for `hold` cycles and pokes in_valid meanwhile.
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s, input int hold,
                      input bit poke, output logic [33:0] got, output int lat);
    @(posedge clk); #1;
    a8 = x; b8 = y; sub = s; in_valid = 1'b1;
    @(negedge clk);
    chk("accept in_ready", 34'(in_ready), 34'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a8 = ~x; b8 = 8'h5A; sub = ~s;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency 8/1", 34'(lat), 34'd9);
    got = {ovf, cout, 24'd0, result};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (poke && i == 5) begin
        in_valid = 1'b1; a8 = 8'd1; b8 = 8'd1; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (poke && i == 5) chk("bp in_ready low", 34'(in_ready), 34'd0);
      chk("bp result held", {ovf, cout, 24'd0, result}, got);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain in_ready", 34'(in_ready), 34'd1);
    chk("drain out_valid", 34'(out_valid), 34'd0);
  endtask

  // Same operands into both 16-bit instances; latency counted independently for each.
  task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic s,
                       output logic [33:0] got4, output logic [33:0] got16,
                       output int lat4, output int lat16);
    bit g4, g16;
    g4 = 1'b0; g16 = 1'b0; lat4 = 0; lat16 = 0;
    got4 = '0; got16 = '0;
    @(posedge clk); #1;
    a16 = x; b16 = y; sub16 = s; iv16 = 1'b1;
    @(negedge clk);
    chk("w16 accept ready", 34'({w4_ir, w16_ir}), 34'd3);
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = 16'hA5A5; b16 = ~y;
    for (int t = 1; t <= 40 && !(g4 && g16); t++) begin
      @(negedge clk);
      if (!g4 && w4_ov) begin
        g4 = 1'b1; lat4 = t; got4 = {w4_v, w4_c, 16'd0, w4_r};
      end
      if (!g16 && w16_ov) begin
        g16 = 1'b1; lat16 = t; got16 = {w16_v, w16_c, 16'd0, w16_r};
      end
    end
    chk("w16d4 latency", 34'(lat4), 34'd5);
    chk("w16d16 latency", 34'(lat16), 34'd2);
    chk("w16d4 model", got4, ref_op(16, 32'(x), 32'(y), s));
    chk("w16d16 model", got16, ref_op(16, 32'(x), 32'(y), s));
    @(posedge clk); #1 or16 = 1'b1;
    @(posedge clk); #1 or16 = 1'b0;
    chk("w16 drain ready", 34'({w4_ir, w16_ir, w4_ov, w16_ov}), 34'b1100);
  endtask

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       s;
  } vec8_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        s;
  } vec16_t;

  initial begin
    logic [33:0] got, g4, g16;
    int lat, l4, l16;
    vec8_t  v8[6];
    vec16_t v16[4];

    v8[0] = '{8'hFF, 8'h01, 1'b0};
    v8[1] = '{8'h00, 8'h00, 1'b1};
    v8[2] = '{8'h7F, 8'h01, 1'b0};
    v8[3] = '{8'h80, 8'h80, 1'b0};
    v8[4] = '{8'h3C, 8'hC3, 1'b1};
    v8[5] = '{8'h01, 8'h80, 1'b1};
    v16[0] = '{16'h8000, 16'h0001, 1'b1};
    v16[1] = '{16'h1234, 16'h4321, 1'b0};
    v16[2] = '{16'h0000, 16'hFFFF, 1'b1};
    v16[3] = '{16'h7FFF, 16'h7FFF, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a8 = '0; b8 = '0;
    iv16 = 1'b0; or16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;

    // Hand-computed values that pin the reference model.
    chk("model 100+55", ref_op(8, 32'd100, 32'd55, 1'b0), {1'b1, 1'b0, 32'd155});
    chk("model 200+100", ref_op(8, 32'd200, 32'd100, 1'b0), {1'b0, 1'b1, 32'd44});
    chk("model 5-10", ref_op(8, 32'd5, 32'd10, 1'b1), {1'b0, 1'b0, 32'd251});
    chk("model 80-1", ref_op(8, 32'h80, 32'h1, 1'b1), {1'b1, 1'b1, 32'h7F});
    chk("model ffff+1", ref_op(16, 32'hFFFF, 32'h1, 1'b0), {1'b0, 1'b1, 32'h0});

    repeat (3) @(posedge clk);
    chk("w16 rst", {w4_ir, w4_ov, w4_bz, w4_c, w4_v, w16_ir, w16_ov, w16_bz, w16_c, w16_v},
        34'b1000010000);
    chk("w16 rst result", {2'b00, w4_r, w16_r}, 34'd0);
    #1 rst_n = 1'b1;

    run8(8'd100, 8'd55, 1'b0, 0, 1'b0, got, lat);
    chk("t1 100+55", got, {1'b1, 1'b0, 32'd155});
    run8(8'd200, 8'd100, 1'b0, 2, 1'b0, got, lat);
    chk("t2 200+100", got, {1'b0, 1'b1, 32'd44});
    run8(8'd5, 8'd10, 1'b1, 1, 1'b0, got, lat);
    chk("t3 5-10", got, {1'b0, 1'b0, 32'd251});
    run8(8'h80, 8'h01, 1'b1, 0, 1'b0, got, lat);
    chk("t3 80-1", got, {1'b1, 1'b1, 32'h7F});

    // Backpressure with an ignored operand pulse while the result is held.
    run8(8'd17, 8'd9, 1'b1, 20, 1'b1, got, lat);
    chk("t4 17-9", got, {1'b0, 1'b1, 32'd8});

    foreach (v8[i]) begin
      run8(v8[i].x, v8[i].y, v8[i].s, i % 3, 1'b0, got, lat);
      chk("vec8 model", got, ref_op(8, 32'(v8[i].x), 32'(v8[i].y), v8[i].s));
    end

    // Reset in the third RUN cycle.
    @(posedge clk); #1;
    a8 = 8'h55; b8 = 8'h11; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("t5 busy before rst", 34'(busy), 34'd1);
    rst_n = 1'b0;
    #1;
    chk("t5 rst flags", {in_ready, out_valid, busy, cout, ovf}, 34'b10000);
    chk("t5 rst result", 34'(result), 34'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run8(8'd3, 8'd4, 1'b0, 0, 1'b0, got, lat);
    chk("t5 3+4", got, {1'b0, 1'b0, 32'd7});

    run16(16'hFFFF, 16'h0001, 1'b0, g4, g16, l4, l16);
    chk("t6 d4 ffff+1", g4, {1'b0, 1'b1, 32'h0});
    chk("t6 d16 ffff+1", g16, {1'b0, 1'b1, 32'h0});
    foreach (v16[i]) run16(v16[i].x, v16[i].y, v16[i].s, g4, g16, l4, l16);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
